// File: rtl/lc3_cc_ben_sequencer.sv
// Per-instruction control sequencer for the LC-3 NZP/BEN datapath (gates, LD_CC, LD_BEN, LD_PC).
// Define LC3_SEQ_TIMEOUT_EN to bound each memory wait to TIMEOUT_CYCLES and pulse timeout_err.
module lc3_cc_ben_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       ben,
  output logic       mem_en,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic       LD_CC,
  output logic       LD_BEN,
  output logic       LD_PC,
  output logic       pc_sel_adder,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [3:0] {
    StIdle, StAluWb, StLeaWb, StMem1, StMem2, StMemWb, StBenLd, StBenChk, StDone
  } state_e;

  state_e state_q, state_d;
  logic   indirect_q, indirect_d;
  logic   mem_timeout;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      indirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      indirect_q <= indirect_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    indirect_d  = indirect_q;
    instr_ready = 1'b0;
    mem_en      = 1'b0;
    GateALU     = 1'b0;
    GateMARMUX  = 1'b0;
    GateMDR     = 1'b0;
    LD_CC       = 1'b0;
    LD_BEN      = 1'b0;
    LD_PC       = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (opcode)
            4'b0001, 4'b0101, 4'b1001: state_d = StAluWb;
            4'b1110:                   state_d = StLeaWb;
            4'b0010, 4'b0110: begin
              state_d    = StMem1;
              indirect_d = 1'b0;
            end
            4'b1010: begin
              state_d    = StMem1;
              indirect_d = 1'b1;
            end
            4'b0000:                   state_d = StBenLd;
            default:                   state_d = StDone;
          endcase
        end
      end
      StAluWb: begin
        GateALU = 1'b1;
        LD_CC   = 1'b1;
        state_d = StDone;
      end
      StLeaWb: begin
        GateMARMUX = 1'b1;
        LD_CC      = 1'b1;
        state_d    = StDone;
      end
      StMem1, StMem2: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          // LDI: the first access fetches the pointer, the second fetches the data.
          if (state_q == StMem1 && indirect_q) begin
            state_d    = StMem2;
            indirect_d = 1'b0;
          end else begin
            state_d = StMemWb;
          end
        end else if (mem_timeout) begin
          state_d = StDone;
        end
      end
      StMemWb: begin
        GateMDR = 1'b1;
        LD_CC   = 1'b1;
        state_d = StDone;
      end
      StBenLd: begin
        LD_BEN  = 1'b1;
        state_d = StBenChk;
      end
      StBenChk: begin
        LD_PC   = ben;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc_sel_adder = LD_PC;
  assign busy         = (state_q != StIdle);

`ifdef LC3_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 in_mem;

  assign in_mem      = (state_q == StMem1) || (state_q == StMem2);
  assign mem_timeout = in_mem && !mem_ready &&
                       (wait_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Staying in the same MEM state means still waiting; any state change restarts the count.
  always_comb begin
    wait_cnt_d = (in_mem && state_d == state_q) ? wait_cnt_q + TIMEOUT_W'(1) : '0;
    timeout_d  = mem_timeout;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign mem_timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_cc_ben_sequencer.sv
// Scoreboard bench for lc3_cc_ben_sequencer: per-instruction expected strobe counts and latency.
module tb_lc3_cc_ben_sequencer;
  localparam int unsigned TO = 16;
`ifdef LC3_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset, instr_valid, mem_ready, ben;
  logic [3:0] opcode;
  logic       instr_ready, mem_en, GateALU, GateMARMUX, GateMDR, LD_CC, LD_BEN, LD_PC;
  logic       pc_sel_adder, busy, done, timeout_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int lat; int alu; int marmux; int mdr; int ldcc; int ldben; int ldpc; int mem; int terr;
  } exp_t;

  exp_t sb[$];
  int   wq[$];

  lc3_cc_ben_sequencer #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_ready(mem_ready), .ben(ben), .mem_en(mem_en), .GateALU(GateALU),
    .GateMARMUX(GateMARMUX), .GateMDR(GateMDR), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .LD_PC(LD_PC),
    .pc_sel_adder(pc_sel_adder), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit timed_out(input int w);
    return TO_EN && (w >= int'(TO));
  endfunction

  // Reference: what one instruction should produce, from its opcode, ben and memory waits.
  function automatic exp_t model(input logic [3:0] op, input logic b, input int w1, input int w2);
    exp_t e;
    int   ws[2];
    int   n;
    e  = '{default: 0};
    ws = '{w1, w2};
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin e.lat = 2; e.alu = 1; e.ldcc = 1; end
      4'b1110:                   begin e.lat = 2; e.marmux = 1; e.ldcc = 1; end
      4'b0000:                   begin e.lat = 3; e.ldben = 1; e.ldpc = int'(b); end
      4'b0010, 4'b0110, 4'b1010: begin
        n = (op == 4'b1010) ? 2 : 1;
        for (int i = 0; i < n; i++) begin
          if (timed_out(ws[i])) begin
            e.mem += TO;
            e.terr = 1;
            break;
          end
          e.mem += ws[i] + 1;
        end
        if (e.terr != 0) e.lat = e.mem + 1;
        else begin e.lat = e.mem + 2; e.mdr = 1; e.ldcc = 1; end
      end
      default: e.lat = 1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic b, input int w1, input int w2,
                       input int gap);
    int n;
    if (gap > 0) begin
      instr_valid = 1'b0;
      repeat (gap) @(negedge Clk);
    end
    n = 0;
    while (!instr_ready && n < 100) begin @(negedge Clk); n++; end
    chk("ready_before_issue", int'(instr_ready), 1);
    opcode = op; ben = b; instr_valid = 1'b1;
    sb.push_back(model(op, b, w1, w2));
    if (op == 4'b0010 || op == 4'b0110 || op == 4'b1010) wq.push_back(w1);
    if (op == 4'b1010 && !timed_out(w1)) wq.push_back(w2);
    @(negedge Clk);
    n = 0;
    // Valid/opcode noise while busy must be ignored.
    while (!done && n < 200) begin
      instr_valid = 1'($urandom); opcode = 4'($urandom);
      @(negedge Clk);
      n++;
    end
    chk("done_within_bound", int'(done), 1);
    instr_valid = 1'($urandom); opcode = 4'($urandom);
    @(negedge Clk);
  endtask

  // Memory responder: raises mem_ready after the queued number of wait cycles per access.
  initial begin : responder
    bit active;
    int cnt, w;
    active = 1'b0; cnt = 0; w = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        active = 1'b0; mem_ready = 1'b0;
      end else if (mem_en) begin
        if (!active || mem_ready) begin
          active = 1'b1; cnt = 0;
          w = (wq.size() > 0) ? wq.pop_front() : 0;
        end else begin
          cnt++;
        end
        mem_ready = (cnt == w);
      end else begin
        active = 1'b0; mem_ready = 1'($urandom);
      end
    end
  end

  initial begin : monitor
    exp_t acc, e;
    bit   ok;
    acc = '{default: 0};
    forever begin
      @(negedge Clk);
      #1;
      if (Reset) begin
        acc = '{default: 0};
        continue;
      end
      ok = ($countones({GateALU, GateMARMUX, GateMDR}) <= 1) &&
           (!LD_CC || (GateALU | GateMARMUX | GateMDR)) && (pc_sel_adder == LD_PC) &&
           (busy != instr_ready) && (!timeout_err || done) &&
           (busy || {mem_en, GateALU, GateMARMUX, GateMDR, LD_CC, LD_BEN, LD_PC, done} == 8'h0);
      chk("cycle_invariants", int'(ok), 1);
      if (busy) begin
        acc.lat++;
        acc.alu += int'(GateALU); acc.marmux += int'(GateMARMUX); acc.mdr += int'(GateMDR);
        acc.ldcc += int'(LD_CC); acc.ldben += int'(LD_BEN); acc.ldpc += int'(LD_PC);
        acc.mem += int'(mem_en); acc.terr += int'(timeout_err);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", acc.lat, e.lat);
          chk("gate_alu_cycles", acc.alu, e.alu);
          chk("gate_marmux_cycles", acc.marmux, e.marmux);
          chk("gate_mdr_cycles", acc.mdr, e.mdr);
          chk("ld_cc_cycles", acc.ldcc, e.ldcc);
          chk("ld_ben_cycles", acc.ldben, e.ldben);
          chk("ld_pc_cycles", acc.ldpc, e.ldpc);
          chk("mem_en_cycles", acc.mem, e.mem);
          chk("timeout_err", acc.terr, e.terr);
        end
        acc = '{default: 0};
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] op;
    int         w1, w2;
    Reset = 1'b1; instr_valid = 1'b0; opcode = 4'h0; mem_ready = 1'b0; ben = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    chk("reset_outputs", int'({instr_ready, mem_en, GateALU, GateMARMUX, GateMDR, LD_CC, LD_BEN,
                               LD_PC, pc_sel_adder, busy, done, timeout_err}), 'h800);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    issue(4'b0001, 1'b0, 0, 0, 0);   // ADD
    issue(4'b0101, 1'b1, 0, 0, 1);   // AND
    issue(4'b1001, 1'b0, 0, 0, 0);   // NOT
    issue(4'b1110, 1'b0, 0, 0, 2);   // LEA
    issue(4'b0000, 1'b1, 0, 0, 0);   // BR taken
    issue(4'b0000, 1'b0, 0, 0, 1);   // BR not taken
    issue(4'b1010, 1'b0, 2, 2, 0);   // LDI, two 3-cycle bursts
    issue(4'b0010, 1'b0, 0, 0, 0);   // LD, single-cycle access
    issue(4'b0110, 1'b1, 3, 0, 1);   // LDR
    issue(4'b1111, 1'b0, 0, 0, 0);   // unsupported opcode, back-to-back
    issue(4'b1101, 1'b1, 0, 0, 0);
    issue(4'b0010, 1'b0, 15, 0, 0);  // just under the timeout limit
    issue(4'b0010, 1'b0, 20, 0, 0);  // timeout when enabled, long wait otherwise
    issue(4'b1010, 1'b1, 20, 1, 0);
    issue(4'b1010, 1'b0, 1, 16, 0);

    // Asynchronous reset in the middle of ALU_WB.
    instr_valid = 1'b1; opcode = 4'b0001;
    @(negedge Clk);
    instr_valid = 1'b0;
    #2;
    chk("pre_reset_gate_alu", int'(GateALU), 1);
    #1;
    Reset = 1'b1;
    #1;
    chk("async_reset_gate_alu", int'(GateALU), 0);
    chk("async_reset_ld_cc", int'(LD_CC), 0);
    chk("async_reset_ready", int'(instr_ready), 1);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      w1 = $urandom_range(0, 3);
      w2 = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) w1 = $urandom_range(14, 18);
      issue(op, 1'($urandom), w1, w2, $urandom_range(0, 2));
    end

    instr_valid = 1'b0;
    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
